// File: rtl/mem_responder.sv
// mem_responder: single-port word store answering requests after WAIT_CYCLES wait states,
// followed by a fixed DONE/TURN turnaround. Define MEM_RESP_PROTO_CHECK_EN for the sticky checker on proto_err.
module mem_responder #(
  parameter int A_WIDTH     = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] m_a,
  input  logic [31:0]        m_din,
  output logic [31:0]        m_dout,
  input  logic               m_strobe,
  input  logic [3:0]         m_wen,
  input  logic [1:0]         m_size,
  input  logic               m_rw,
  output logic               m_ready,
  output logic               proto_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, TURN} state_t;

  state_t                state;
  logic [3:0]            count;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           din_q;
  logic [3:0]            wen_q;
  logic                  rw_q;
  logic [31:0]           store [2**DEPTH_LOG2];
  logic                  finish;
  logic                  unused;

  // Transfer size and the address bits outside the word index play no part in the access.
  assign unused = ^{m_size, m_a};
  assign finish = (state == BUSY) && (count == 4'd0);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= IDLE;
      count   <= 4'd0;
      m_ready <= 1'b0;
      m_dout  <= 32'd0;
      idx_q   <= '0;
      din_q   <= 32'd0;
      wen_q   <= 4'd0;
      rw_q    <= 1'b0;
    end else begin
      m_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (m_strobe) begin
            idx_q <= m_a[DEPTH_LOG2+1:2];
            din_q <= m_din;
            wen_q <= m_wen;
            rw_q  <= m_rw;
            count <= 4'(WAIT_CYCLES);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (count == 4'd0) begin
            state   <= DONE;
            m_ready <= 1'b1;
            if (!rw_q) m_dout <= store[idx_q];
          end else begin
            count <= count - 4'd1;
          end
        end
        DONE:    state <= TURN;
        TURN:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The store has no reset; an aborted access never reaches BUSY with count 0, so it never commits.
  always_ff @(posedge clk) begin
    if (finish && rw_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wen_q[b]) store[idx_q][8*b +: 8] <= din_q[8*b +: 8];
      end
    end
  end

`ifdef MEM_RESP_PROTO_CHECK_EN
  logic [A_WIDTH-1:0] a_q;

  // Initiator must hold strobe and request fields stable for the whole BUSY phase.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      a_q       <= '0;
      proto_err <= 1'b0;
    end else begin
      if (state == IDLE && m_strobe) a_q <= m_a;
      if (state == BUSY && (!m_strobe || m_a != a_q || m_rw != rw_q || m_wen != wen_q))
        proto_err <= 1'b1;
    end
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vector table, reset/protocol corner cases and randomized
// accesses against a word-array model; a second instance covers WAIT_CYCLES=0.
module tb_mem_responder;

  localparam int W = 2;
`ifdef MEM_RESP_PROTO_CHECK_EN
  localparam logic PROTO_EN = 1'b1;
`else
  localparam logic PROTO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] m_a, m_din, m_dout;
  logic        m_strobe, m_rw, m_ready, proto_err;
  logic [3:0]  m_wen;
  logic [1:0]  m_size;

  logic        s0_strobe;
  logic [31:0] s0_dout;
  logic        s0_ready, s0_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [1024];
  logic [31:0] exp_dout;

  always #5 clk = ~clk;

  mem_responder #(.A_WIDTH(32), .DEPTH_LOG2(10), .WAIT_CYCLES(W)) dut (
    .clk(clk), .clrn(clrn), .m_a(m_a), .m_din(m_din), .m_dout(m_dout),
    .m_strobe(m_strobe), .m_wen(m_wen), .m_size(m_size), .m_rw(m_rw),
    .m_ready(m_ready), .proto_err(proto_err)
  );

  mem_responder #(.A_WIDTH(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .clrn(clrn), .m_a(32'h8), .m_din(32'h0F0F0F0F), .m_dout(s0_dout),
    .m_strobe(s0_strobe), .m_wen(4'hF), .m_size(2'b10), .m_rw(1'b1),
    .m_ready(s0_ready), .proto_err(s0_err)
  );

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  wen;
    logic [31:0] expect_rd;
  } vec_t;

  vec_t vecs[11];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] din, input logic [3:0] wen);
    logic [31:0] mask;
    mask = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
    model_mem[addr[11:2]] = (model_mem[addr[11:2]] & ~mask) | (din & mask);
  endfunction

  // One complete handshake; strobe and fields stay put until m_ready, m_din is scrambled mid-access.
  task automatic apply_stimulus(input logic rw, input logic [31:0] addr, input logic [31:0] din,
                                input logic [3:0] wen, output logic [31:0] rdata);
    int lat;
    @(negedge clk);
    m_strobe = 1'b1; m_rw = rw; m_a = addr; m_din = din; m_wen = wen; m_size = 2'($urandom);
    @(posedge clk);
    @(negedge clk);
    m_din = $urandom;
    lat = 0;
    while (lat < 2) begin
      lat++;
      @(posedge clk); #1;
      if (m_ready) break;
    end
    while (!m_ready && lat <= 40) begin
      lat++;
      @(posedge clk); #1;
    end
    check_output("ready_latency", 32'(lat), 32'(W + 1));
    rdata = m_dout;
    if (rw) begin
      check_output("write_keeps_dout", m_dout, exp_dout);
      model_write(addr, din, wen);
    end else begin
      exp_dout = model_mem[addr[11:2]];
      check_output("read_data", m_dout, exp_dout);
    end
    m_strobe = 1'b0;
    @(posedge clk); #1;
    check_output("ready_one_cycle", 32'(m_ready), 32'd0);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int lat;
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1111, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0100, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'b0000, 32'h11BB_3344};
    vecs[5]  = '{1'b1, 32'h0000_1004, 32'h1234_5678, 4'b1111, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0004, 32'h0,         4'b0000, 32'h1234_5678};
    vecs[7]  = '{1'b1, 32'h0000_0030, 32'h0102_0304, 4'b1111, 32'h0};
    vecs[8]  = '{1'b1, 32'h0000_0030, 32'hFFFF_FFFF, 4'b0000, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_0033, 32'h0,         4'b0000, 32'h0102_0304};
    vecs[10] = '{1'b0, 32'hFFFF_F010, 32'h0,         4'b0000, 32'hDEAD_BEEF};

    clrn = 1'b0; m_strobe = 1'b0; m_rw = 1'b0; m_a = 32'h0; m_din = 32'h0;
    m_wen = 4'h0; m_size = 2'b00; s0_strobe = 1'b1; exp_dout = 32'h0;
    #3;
    check_output("reset_ready", 32'(m_ready), 32'd0);
    check_output("reset_dout", m_dout, 32'd0);
    check_output("reset_proto_err", 32'(proto_err), 32'd0);
    repeat (2) @(posedge clk);

    // Zero wait states with strobe held high: ready every 4th cycle, accepted on the release edge.
    @(negedge clk);
    clrn = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      check_output("w0_ready_pattern", 32'(s0_ready), 32'((k % 4) == 1));
    end
    s0_strobe = 1'b0;

    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].rw, vecs[i].addr, vecs[i].din, vecs[i].wen, rd);
      if (!vecs[i].rw) check_output("vector_read", rd, vecs[i].expect_rd);
    end

    // Reset in the second BUSY cycle of a write must abort it without a ready pulse.
    apply_stimulus(1'b1, 32'h40, 32'h0BAD_F00D, 4'hF, rd);
    @(negedge clk);
    m_strobe = 1'b1; m_rw = 1'b1; m_a = 32'h40; m_din = 32'h5555_5555; m_wen = 4'hF;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    clrn = 1'b0;
    m_strobe = 1'b0;
    #1;
    check_output("abort_dout_cleared", m_dout, 32'd0);
    exp_dout = 32'h0;
    repeat (2) begin
      @(posedge clk); #1;
      check_output("abort_no_ready_in_reset", 32'(m_ready), 32'd0);
    end
    @(negedge clk);
    clrn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_output("abort_no_ready_after", 32'(m_ready), 32'd0);
    end
    apply_stimulus(1'b0, 32'h40, 32'h0, 4'h0, rd);
    check_output("abort_old_contents", rd, 32'h0BAD_F00D);

    for (int i = 0; i < 16; i++)
      apply_stimulus(1'b1, 32'(i * 4 + 32'h100), $urandom, 4'hF, rd);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] addr;
      addr = {20'($urandom), 2'b01, 6'($urandom_range(0, 15)), 2'($urandom)};
      apply_stimulus(1'($urandom), addr, $urandom, 4'($urandom), rd);
    end
    check_output("proto_clean_run", 32'(proto_err), 32'd0);

    // Address changed mid-BUSY: flag follows the macro, access still uses the captured address.
    apply_stimulus(1'b1, 32'h54, 32'h7777_7777, 4'hF, rd);
    @(negedge clk);
    m_strobe = 1'b1; m_rw = 1'b1; m_a = 32'h50; m_din = 32'h600D_CAFE; m_wen = 4'hF;
    @(posedge clk); #1;
    check_output("proto_before_change", 32'(proto_err), 32'd0);
    @(negedge clk);
    m_a = 32'h54;
    @(posedge clk); #1;
    check_output("proto_set", 32'(proto_err), 32'(PROTO_EN));
    lat = 1;
    while (!m_ready && lat <= 10) begin
      lat++;
      @(posedge clk); #1;
    end
    check_output("proto_ready_latency", 32'(lat), 32'(W + 1));
    model_write(32'h50, 32'h600D_CAFE, 4'hF);
    m_strobe = 1'b0;
    @(posedge clk); @(posedge clk);
    apply_stimulus(1'b0, 32'h50, 32'h0, 4'h0, rd);
    apply_stimulus(1'b0, 32'h54, 32'h0, 4'h0, rd);
    check_output("proto_sticky", 32'(proto_err), 32'(PROTO_EN));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
